// File: rtl/trace_icache_fetch_queue_pkg.sv
// Shared types and constants for the trace I-cache fetch queue.
package trace_icache_pkg;

    localparam int unsigned LINE_BYTES       = 64;
    localparam logic [63:0] FETCH_ALIGN_MASK = 64'hffff_ffff_ffff_ffe0;

    typedef struct packed {
        logic [63:0]  addr;
        logic [511:0] data;
        logic         fault;
    } fetch_line_t;

endpackage

// File: rtl/trace_icache_fetch_queue_if.sv
// Request, helper and response signals of the fetch queue; slave is the queue's view.
interface trace_icache_fetch_queue_if;

    logic         req_valid;
    logic         req_ready;
    logic [63:0]  req_addr;
    logic         flush;

    logic         helper_enable;
    logic [63:0]  helper_addr;
    logic [63:0]  helper_data0;
    logic [63:0]  helper_data1;
    logic [63:0]  helper_data2;
    logic [63:0]  helper_data3;
    logic [63:0]  helper_data4;
    logic [63:0]  helper_data5;
    logic [63:0]  helper_data6;
    logic [63:0]  helper_data7;
    logic [7:0]   helper_legal;

    logic         resp_valid;
    logic         resp_ready;
    logic [63:0]  resp_addr;
    logic [511:0] resp_data;
    logic         resp_fault;

    modport slave (
        input  req_valid, req_addr, flush, resp_ready, helper_legal,
        input  helper_data0, helper_data1, helper_data2, helper_data3,
        input  helper_data4, helper_data5, helper_data6, helper_data7,
        output req_ready, helper_enable, helper_addr,
        output resp_valid, resp_addr, resp_data, resp_fault
    );

    modport master (
        output req_valid, req_addr, flush, resp_ready, helper_legal,
        output helper_data0, helper_data1, helper_data2, helper_data3,
        output helper_data4, helper_data5, helper_data6, helper_data7,
        input  req_ready, helper_enable, helper_addr,
        input  resp_valid, resp_addr, resp_data, resp_fault
    );

endinterface

// File: rtl/trace_icache_fetch_queue_fifo.sv
// Circular buffer of captured fetch lines with synchronous clear.
module fetch_line_fifo
    import trace_icache_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            push,
    input  fetch_line_t     push_line,
    input  logic            pop,
    input  logic            clear,
    output logic [CntW-1:0] count,
    output logic            empty,
    output fetch_line_t     head
);

    localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

    fetch_line_t            mem_q [DEPTH];
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        count_q, count_d;
    logic                   do_push, do_pop;

    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !clear;
    assign do_pop  = pop && !clear && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= push_line;
        end
    end

    // Upstream credit accounting must make an overflowing push impossible.
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(do_push && !do_pop && count_q == FullCount));

endmodule

// File: rtl/trace_icache_fetch_queue.sv
// Issues fetches to the trace I-cache helper and queues the returned lines for the frontend.
module trace_icache_fetch_queue
    import trace_icache_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input logic                        clock,
    input logic                        reset_n,
    trace_icache_fetch_queue_if.slave  bus
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic              inflight_q, inflight_d;
    logic [63:0]       inflight_addr_q, inflight_addr_d;
    logic [PtrW:0]     fifo_count;
    logic              fifo_empty;
    fetch_line_t       fifo_head;
    fetch_line_t       push_line;
    logic              fire_req;
    logic              push, pop;
    logic [PtrW+1:0]   used_slots;
    logic              line_fault;

    // Inflight counts as a reserved slot so a capture never finds the FIFO full.
    assign used_slots = {1'b0, fifo_count} + (PtrW+2)'(inflight_q);
    assign line_fault = (bus.helper_legal == 8'h00);

    always_comb begin
        bus.req_ready     = !bus.flush && (used_slots < (PtrW+2)'(DEPTH));
        fire_req          = bus.req_valid && bus.req_ready;
        bus.helper_enable = fire_req;
        bus.helper_addr   = fire_req ? (bus.req_addr & FETCH_ALIGN_MASK) : 64'h0;

        inflight_d      = fire_req;
        inflight_addr_d = fire_req ? (bus.req_addr & FETCH_ALIGN_MASK) : inflight_addr_q;

        push            = inflight_q && !bus.flush;
        pop             = !fifo_empty && bus.resp_ready && !bus.flush;
        push_line.addr  = inflight_addr_q;
        push_line.fault = line_fault;
        push_line.data  = line_fault ? 512'h0 :
            {bus.helper_data7, bus.helper_data6, bus.helper_data5, bus.helper_data4,
             bus.helper_data3, bus.helper_data2, bus.helper_data1, bus.helper_data0};

        bus.resp_valid = !fifo_empty;
        bus.resp_addr  = fifo_empty ? 64'h0  : fifo_head.addr;
        bus.resp_data  = fifo_empty ? 512'h0 : fifo_head.data;
        bus.resp_fault = !fifo_empty && fifo_head.fault;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q      <= 1'b0;
            inflight_addr_q <= 64'h0;
        end else begin
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
        end
    end

    fetch_line_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_line (push_line),
        .pop       (pop),
        .clear     (bus.flush),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

endmodule

// File: tb/tb_trace_icache_fetch_queue.sv
// Directed vector bench for trace_icache_fetch_queue.
module tb_trace_icache_fetch_queue;

    typedef struct {
        logic        rv;
        logic [63:0] addr;
        logic        rr;
        logic        fl;
        logic [63:0] hmul;
        logic        hlegal;
        logic        e_rdy;
        logic        e_en;
        logic [63:0] e_haddr;
        logic        e_rv;
        logic [63:0] e_raddr;
        logic        e_fault;
        logic [63:0] e_mul;
    } vec_t;

    localparam logic [63:0] H  = 64'h1111_1111_1111_1111;
    localparam logic [63:0] D  = 64'hdead_dead_dead_dead;
    localparam logic [63:0] H1 = 64'h0101_0101_0101_0101;
    localparam logic [63:0] H2 = 64'h0202_0202_0202_0202;
    localparam logic [63:0] H3 = 64'h0303_0303_0303_0303;

    logic clock;
    logic reset_n;
    int   n_vec;
    int   n_err;
    vec_t vt [15];

    trace_icache_fetch_queue_if bus ();

    trace_icache_fetch_queue #(
        .DEPTH (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [511:0] line(input logic [63:0] mul);
        logic [511:0] l;
        for (int i = 0; i < 8; i++) l[64*i +: 64] = mul * 64'(i + 1);
        return l;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_helper(input logic [63:0] mul, input logic legal);
        bus.helper_data0 = mul * 64'd1;
        bus.helper_data1 = mul * 64'd2;
        bus.helper_data2 = mul * 64'd3;
        bus.helper_data3 = mul * 64'd4;
        bus.helper_data4 = mul * 64'd5;
        bus.helper_data5 = mul * 64'd6;
        bus.helper_data6 = mul * 64'd7;
        bus.helper_data7 = mul * 64'd8;
        bus.helper_legal = legal ? 8'h80 : 8'h00;
    endtask

    task automatic drive_req(input logic rv, input logic [63:0] addr, input logic rr,
                             input logic fl);
        bus.req_valid  = rv;
        bus.req_addr   = addr;
        bus.resp_ready = rr;
        bus.flush      = fl;
    endtask

    initial begin
        logic [63:0] prev_addr;
        logic        prev_acc;
        logic        cur;
        int          acc;
        n_vec = 0;
        n_err = 0;

        //       rv addr           rr fl hmul hl  rdy en haddr         rv raddr          flt mul
        vt[0]  = '{0, 64'h0,          0, 0, 0,  1,  1, 0, 64'h0,          0, 64'h0,          0, 0};
        vt[1]  = '{1, 64'h8000_0014,  0, 0, 0,  1,  1, 1, 64'h8000_0000,  0, 64'h0,          0, 0};
        vt[2]  = '{0, 64'h0,          0, 0, H,  1,  1, 0, 64'h0,          0, 64'h0,          0, 0};
        vt[3]  = '{0, 64'h0,          0, 0, 0,  1,  1, 0, 64'h0,          1, 64'h8000_0000,  0, H};
        vt[4]  = '{0, 64'h0,          1, 0, 0,  1,  1, 0, 64'h0,          1, 64'h8000_0000,  0, H};
        vt[5]  = '{1, 64'hdead_005c,  1, 0, 0,  1,  1, 1, 64'hdead_0040,  0, 64'h0,          0, 0};
        vt[6]  = '{0, 64'h0,          1, 0, D,  0,  1, 0, 64'h0,          0, 64'h0,          0, 0};
        vt[7]  = '{0, 64'h0,          1, 0, 0,  1,  1, 0, 64'h0,          1, 64'hdead_0040,  1, 0};
        vt[8]  = '{0, 64'h0,          1, 0, 0,  1,  1, 0, 64'h0,          0, 64'h0,          0, 0};
        vt[9]  = '{1, 64'h2000,       0, 0, 0,  1,  1, 1, 64'h2000,       0, 64'h0,          0, 0};
        vt[10] = '{1, 64'h2020,       0, 0, H1, 1,  1, 1, 64'h2020,       0, 64'h0,          0, 0};
        vt[11] = '{1, 64'h2047,       0, 0, H2, 1,  1, 1, 64'h2040,       1, 64'h2000,       0, H1};
        vt[12] = '{1, 64'h3000,       0, 1, H3, 1,  0, 0, 64'h0,          1, 64'h2000,       0, H1};
        vt[13] = '{0, 64'h0,          0, 0, H3, 1,  1, 0, 64'h0,          0, 64'h0,          0, 0};
        vt[14] = '{0, 64'h0,          0, 0, 0,  1,  1, 0, 64'h0,          0, 64'h0,          0, 0};

        reset_n = 1'b0;
        drive_req(0, 64'h0, 0, 0);
        set_helper(64'h0, 1'b1);
        #1;
        check("in_reset resp_valid", 512'(bus.resp_valid), 512'(0));
        check("in_reset req_ready", 512'(bus.req_ready), 512'(1));
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Single request, fault, and flush with a line in flight.
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            drive_req(vt[i].rv, vt[i].addr, vt[i].rr, vt[i].fl);
            set_helper(vt[i].hmul, vt[i].hlegal);
            #1;
            check($sformatf("row%0d req_ready", i), 512'(bus.req_ready), 512'(vt[i].e_rdy));
            check($sformatf("row%0d helper_enable", i), 512'(bus.helper_enable),
                  512'(vt[i].e_en));
            check($sformatf("row%0d helper_addr", i), 512'(bus.helper_addr),
                  512'(vt[i].e_haddr));
            check($sformatf("row%0d resp_valid", i), 512'(bus.resp_valid), 512'(vt[i].e_rv));
            check($sformatf("row%0d resp_addr", i), 512'(bus.resp_addr), 512'(vt[i].e_raddr));
            check($sformatf("row%0d resp_fault", i), 512'(bus.resp_fault),
                  512'(vt[i].e_fault));
            check($sformatf("row%0d resp_data", i), bus.resp_data, line(vt[i].e_mul));
        end

        // Back-to-back: eight requests, responses on consecutive cycles from T+2.
        for (int c = 0; c < 11; c++) begin
            @(negedge clock);
            drive_req(c < 8, 64'h1000 + 64'(32 * c), 1, 0);
            if (c >= 1 && c <= 8) set_helper(64'h1000 + 64'(32 * (c - 1)), 1'b1);
            else set_helper(64'h0, 1'b1);
            #1;
            if (c < 8) check($sformatf("b2b%0d req_ready", c), 512'(bus.req_ready), 512'(1));
            if (c >= 2 && c < 10) begin
                check($sformatf("b2b%0d resp_valid", c), 512'(bus.resp_valid), 512'(1));
                check($sformatf("b2b%0d resp_addr", c), 512'(bus.resp_addr),
                      512'(64'h1000 + 64'(32 * (c - 2))));
                check($sformatf("b2b%0d resp_data", c), bus.resp_data,
                      line(64'h1000 + 64'(32 * (c - 2))));
            end else begin
                check($sformatf("b2b%0d resp_valid", c), 512'(bus.resp_valid), 512'(0));
            end
        end

        // Backpressure: only DEPTH requests get credit while the consumer stalls.
        acc = 0;
        prev_acc = 1'b0;
        prev_addr = 64'h0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            drive_req(1, 64'h4000 + 64'(32 * acc), 0, 0);
            set_helper(prev_acc ? prev_addr : 64'h0, 1'b1);
            #1;
            cur = bus.req_ready;
            if (cur) acc++;
            prev_acc = cur;
            prev_addr = bus.req_addr;
        end
        check("bp accepted", 512'(acc), 512'(4));
        check("bp req_ready_low", 512'(bus.req_ready), 512'(0));
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            drive_req(0, 64'h0, 1, 0);
            set_helper(64'h0, 1'b1);
            #1;
            check($sformatf("bp%0d resp_valid", k), 512'(bus.resp_valid), 512'(1));
            check($sformatf("bp%0d resp_addr", k), 512'(bus.resp_addr),
                  512'(64'h4000 + 64'(32 * k)));
            check($sformatf("bp%0d resp_data", k), bus.resp_data, line(64'h4000 + 64'(32 * k)));
        end
        @(negedge clock);
        #1;
        check("bp drained resp_valid", 512'(bus.resp_valid), 512'(0));
        check("bp drained req_ready", 512'(bus.req_ready), 512'(1));

        // Async reset with three lines buffered.
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            drive_req(c < 3, 64'h5000 + 64'(32 * c), 0, 0);
            set_helper((c >= 1 && c <= 3) ? 64'h5000 + 64'(32 * (c - 1)) : 64'h0, 1'b1);
        end
        #1;
        check("ar buffered resp_valid", 512'(bus.resp_valid), 512'(1));
        check("ar buffered resp_addr", 512'(bus.resp_addr), 512'(64'h5000));
        check("ar buffered req_ready", 512'(bus.req_ready), 512'(1));
        #1;
        reset_n = 1'b0;
        #1;
        check("ar resp_valid", 512'(bus.resp_valid), 512'(0));
        check("ar resp_addr", 512'(bus.resp_addr), 512'(0));
        check("ar resp_data", bus.resp_data, 512'(0));
        check("ar resp_fault", 512'(bus.resp_fault), 512'(0));
        check("ar helper_enable", 512'(bus.helper_enable), 512'(0));
        check("ar helper_addr", 512'(bus.helper_addr), 512'(0));
        check("ar req_ready", 512'(bus.req_ready), 512'(1));
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        drive_req(0, 64'h0, 1, 0);
        #1;
        check("ar released req_ready", 512'(bus.req_ready), 512'(1));
        check("ar released resp_valid", 512'(bus.resp_valid), 512'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/trace_icache_fetch_queue.md
# trace_icache_fetch_queue

Request front-end for the trace I-cache helper (TraceICacheHelper). It accepts fetch requests over a valid/ready handshake, drives the helper's `enable`/`addr` pins, and captures the 512-bit line the helper returns one cycle later. Each captured line is buffered in a small FIFO and presented to the frontend as a line response with a fault flag. It sits between the fetch-stage model and the DPI-backed helper in the trace-driven simulation top.

## Interface
- `DEPTH`, 4: response FIFO entries; power of two, minimum 2. `DEPTH >= 3` is required for 1 req/cycle throughput.
- `clock`  in  1  single clock; all state updates on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  fetch request valid.
- `req_ready`  out  1  request can be accepted this cycle.
- `req_addr`  in  64  fetch byte address; any alignment.
- `flush`  in  1  discard all buffered and in-flight lines.
- `helper_enable`  out  1  to helper `enable`.
- `helper_addr`  out  64  to helper `addr`.
- `helper_data0`..`helper_data7`  in  64 each  helper `data0`..`data7`.
- `helper_legal`  in  8  helper `legal_addr`; nonzero means legal.
- `resp_valid`  out  1  response entry at FIFO head.
- `resp_ready`  in  1  consumer accepts the head entry.
- `resp_addr`  out  64  line base, `req_addr & ~64'h1f`.
- `resp_data`  out  512  `resp_data[64*i +: 64] = helper_data<i>`.
- `resp_fault`  out  1  helper reported an illegal address.

## Operation
- **Accept:** `fire_req = req_valid && req_ready`. The accept rule is `req_ready = !flush && (count + inflight) < DEPTH`. It does not look ahead to a same-cycle pop.
- **Issue:** on `fire_req`, combinationally drive `helper_enable = 1` and `helper_addr = req_addr & ~64'h1f`. Both outputs are 0 otherwise. On the same edge, set `inflight <= 1` and `inflight_addr <= aligned addr`.
- **Capture:** in the cycle after issue (`inflight == 1`), the helper outputs are valid. At the end of that cycle, push `{inflight_addr, data0..7, helper_legal == 0}` into the FIFO.
- **Fault:** when the helper reports illegal, push `resp_fault = 1` and force the data field to all zeros.
- **Pop:** `fire_resp = resp_valid && resp_ready`. `resp_*` show the FIFO head; `resp_valid = (count != 0)`.
- **Simultaneous push and pop:** `count` is unchanged and both pointers advance.
- **Full:** push can never find the FIFO full, because the credit rule counts `inflight`. An assertion fires if it does.
- **Flush:** on the next edge, clear `count`, both pointers and `inflight`. A helper line arriving the cycle after a flush is not captured.
  - `flush` has priority over `fire_req`, push and pop in the same cycle.
  - During the flush cycle, `req_ready = 0` and `helper_enable = 0`.
- **Pointers:** `log2(DEPTH)` bits, natural wrap. `count` is `log2(DEPTH)+1` bits.

## Timing
- Reset values: `req_ready = 1` after reset, since it is derived from `count = 0, inflight = 0`. `helper_enable = 0`, `helper_addr = 0`, `resp_valid = 0`, `resp_addr = 0`, `resp_data = 0`, `resp_fault = 0`. Storage is cleared.
- `reset_n` asserted mid-operation: in-flight and buffered lines are lost immediately. No response is emitted for them.
- Latency: request accepted in cycle T → line captured at the end of T+1 → `resp_valid` in T+2.
- Throughput: 1 line/cycle sustained when `DEPTH >= 3` and `resp_ready` is held high.
- `resp_*` are stable while `resp_valid && !resp_ready`, except across a flush.

## Structure
- Package `trace_icache_pkg`:
  - `LINE_BYTES = 64`
  - `FETCH_ALIGN_MASK = 64'hffff_ffff_ffff_ffe0`
  - typedef `fetch_line_t {logic [63:0] addr; logic [511:0] data; logic fault;}`
- Sub-module `fetch_line_fifo`, parameterised on `DEPTH` and storing `fetch_line_t`. It has `push`/`pop`/`clear` and `count`/`empty`/`head` outputs, and the same `clock`/`reset_n`.
- The top level holds the issue/inflight register, the credit logic and the fault masking.

## Test plan
- **Single request:** `req_addr = 0x8000_0014`, helper legal, data `i = 0x1111_1111_1111_1111*(i+1)`. Expect `helper_addr = 0x8000_0000` in T; `resp_valid` in T+2 with `resp_addr = 0x8000_0000` and `resp_data[63:0] = 0x1111_1111_1111_1111`.
- **Back-to-back:** 8 requests at `0x1000 + 0x20*k` with `resp_ready = 1`. Expect 8 responses on consecutive cycles starting at T+2, in order, with `req_ready` never dropping.
- **Backpressure:** `resp_ready = 0`, issue 6 requests. Expect exactly 4 accepted and `req_ready = 0` thereafter. After `resp_ready = 1`, expect 4 in-order responses, then `req_ready` returns to 1.
- **Fault:** helper returns `legal = 0` with data all `0xdead…`. Expect `resp_fault = 1` and `resp_data = 0`.
- **Flush with in-flight:** assert `flush` in T+1 after an accept in T with 2 lines buffered. Expect `resp_valid = 0` from T+2, and no response for the in-flight line.
- **Async reset:** drop `reset_n` mid-cycle with 3 lines buffered. Expect all outputs at their reset values immediately, and `req_ready = 1` after release.
